// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state, opcode and control-field encodings for the multicycle MIPS controller
// Purpose: the controller and the datapath import this package so that both sides agree on
//          the FSM states, the decoded opcode/funct values and the meaning of each mux select.
// Ports:   none (package).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_R_EX, S_R_WB, S_ADDI_EX, S_ANDI_EX, S_IMM_WB, S_MEM_ADDR,
    S_LW_RD, S_LW_WB, S_SW_WR, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ERROR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] ALUB_REGB    = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - saturating wait-state watchdog for one memory access
// Purpose: counts cycles spent waiting for mem_ready and flags the cycle on which the
//          MEM_TIMEOUT-th consecutive wait cycle completes without ready.
// Ports:   clk, rst (sync, active-low), clear (zero the count), tick (a wait state is active),
//          ready (memory completed this cycle), expired (combinational timeout flag).
module mc_wait_timer #(
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  input  logic ready,
  output logic expired
);

  logic [TMO_W-1:0] r_count;
  logic             w_wait;

  assign w_wait = tick & ~ready;

  // r_count holds the wait cycles already completed, so the current cycle is wait number
  // r_count+1; a ready in that same cycle suppresses the flag.
  assign expired = w_wait & (r_count == TMO_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_count <= '0;
    end else if (w_wait && (r_count != '1)) begin
      r_count <= r_count + TMO_W'(1);
    end
  end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle MIPS control FSM with memory handshake, watchdog and halt
// Purpose: sequences FETCH/DECODE/execute/writeback and drives the datapath strobes.
// Ports:   clk, rst (sync, active-low); opcode/funct from IR; mem_ready handshake input;
//          mem_req/memread/memwrite/IorD memory controls; IR_write, pc_write,
//          pc_write_condition, branch_ne, pcsrc PC controls; alusrcA, alusrcB, toaluctrl ALU
//          controls; regwrite, regdst, memtoreg register-file controls; instr_done pulse;
//          halt and err_code status.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int FUNCT_W     = 6,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                memread,
  output logic                memwrite,
  output logic                IorD,
  output logic                IR_write,
  output logic                pc_write,
  output logic                pc_write_condition,
  output logic                branch_ne,
  output logic [1:0]          pcsrc,
  output logic                alusrcA,
  output logic [1:0]          alusrcB,
  output logic [1:0]          toaluctrl,
  output logic                regwrite,
  output logic [1:0]          regdst,
  output logic [1:0]          memtoreg,
  output logic                instr_done,
  output logic                halt,
  output logic [1:0]          err_code
);

  state_t     r_state;
  logic [1:0] r_err;
  logic       r_bne;    // branch flavour captured in DECODE while IR is stable
  logic       r_is_sw;  // load/store direction captured in DECODE
  logic       w_in_wait;
  logic       w_expired;

  assign w_in_wait = (r_state == S_FETCH) || (r_state == S_LW_RD) || (r_state == S_SW_WR);

  // Every exit from a wait state happens on mem_ready (or into ERROR), so clearing on ready
  // or outside the wait states guarantees a zero count on entry to each access.
  mc_wait_timer #(.TMO_W(TMO_W), .MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (~w_in_wait | mem_ready),
    .tick    (w_in_wait),
    .ready   (mem_ready),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_err   <= ERR_NONE;
      r_bne   <= 1'b0;
      r_is_sw <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH, S_LW_RD, S_SW_WR: begin
          if (mem_ready) begin
            r_state <= (r_state == S_FETCH) ? S_DECODE :
                       (r_state == S_LW_RD) ? S_LW_WB : S_FETCH;
          end else if (w_expired) begin
            r_state <= S_ERROR;
            r_err   <= ERR_TIMEOUT;
          end
        end
        S_DECODE: begin
          r_bne   <= opcode[0];
          r_is_sw <= (opcode == OPCODE_W'(OP_SW));
          case (opcode)
            OPCODE_W'(OP_RTYPE):            r_state <= (funct == FUNCT_W'(FN_JR)) ? S_JR : S_R_EX;
            OPCODE_W'(OP_LW), OPCODE_W'(OP_SW):   r_state <= S_MEM_ADDR;
            OPCODE_W'(OP_BEQ), OPCODE_W'(OP_BNE): r_state <= S_BRANCH;
            OPCODE_W'(OP_ADDI):             r_state <= S_ADDI_EX;
            OPCODE_W'(OP_ANDI):             r_state <= S_ANDI_EX;
            OPCODE_W'(OP_J):                r_state <= S_JUMP;
            OPCODE_W'(OP_JAL):              r_state <= S_JAL;
            default: begin
              r_state <= S_ERROR;
              r_err   <= ERR_ILLEGAL;
            end
          endcase
        end
        S_R_EX:               r_state <= S_R_WB;
        S_ADDI_EX, S_ANDI_EX: r_state <= S_IMM_WB;
        S_MEM_ADDR:           r_state <= r_is_sw ? S_SW_WR : S_LW_RD;
        S_ERROR:              r_state <= S_ERROR;
        default:              r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req            = 1'b0;
    memread            = 1'b0;
    memwrite           = 1'b0;
    IorD               = 1'b0;
    IR_write           = 1'b0;
    pc_write           = 1'b0;
    pc_write_condition = 1'b0;
    branch_ne          = 1'b0;
    pcsrc              = PCSRC_ALU;
    alusrcA            = 1'b0;
    alusrcB            = ALUB_REGB;
    toaluctrl          = ALU_ADD;
    regwrite           = 1'b0;
    regdst             = REGDST_RT;
    memtoreg           = M2R_ALUOUT;
    instr_done         = 1'b0;
    halt               = 1'b0;
    err_code           = ERR_NONE;
    if (rst) begin
      err_code = r_err;
      case (r_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          memread  = 1'b1;
          alusrcB  = ALUB_FOUR;
          IR_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE:   alusrcB = ALUB_IMM_SH2;
        S_R_EX: begin
          alusrcA   = 1'b1;
          toaluctrl = ALU_FUNCT;
        end
        S_R_WB: begin
          regwrite   = 1'b1;
          regdst     = REGDST_RD;
          instr_done = 1'b1;
        end
        S_ADDI_EX, S_ANDI_EX, S_MEM_ADDR: begin
          alusrcA   = 1'b1;
          alusrcB   = ALUB_IMM;
          toaluctrl = (r_state == S_ANDI_EX) ? ALU_AND : ALU_ADD;
        end
        S_IMM_WB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_LW_RD: begin
          mem_req = 1'b1;
          memread = 1'b1;
          IorD    = 1'b1;
        end
        S_LW_WB: begin
          regwrite   = 1'b1;
          memtoreg   = M2R_MDR;
          instr_done = 1'b1;
        end
        S_SW_WR: begin
          mem_req    = 1'b1;
          memwrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_BRANCH: begin
          alusrcA            = 1'b1;
          toaluctrl          = ALU_SUB;
          pc_write_condition = 1'b1;
          pcsrc              = PCSRC_ALUOUT;
          branch_ne          = r_bne;
          instr_done         = 1'b1;
        end
        S_JUMP, S_JAL: begin
          pc_write   = 1'b1;
          pcsrc      = PCSRC_JUMP;
          instr_done = 1'b1;
          if (r_state == S_JAL) begin
            regwrite = 1'b1;
            regdst   = REGDST_RA;
            memtoreg = M2R_PC;
          end
        end
        S_JR: begin
          pc_write   = 1'b1;
          pcsrc      = PCSRC_REGA;
          instr_done = 1'b1;
        end
        S_ERROR:    halt = 1'b1;
        default:    halt = 1'b0;
      endcase
    end
  end

endmodule
